shiftreg_rw_ctrl: RTL

SHIFTREG_RW_CTRL -- requirements
Module: shiftreg_rw_ctrl

---
 rtl/shiftreg_rw_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/shiftreg_rw_ctrl.sv
// Serial read/write controller for a chip shift register: shifts a word out MSB first
// on sr_din while capturing sr_dout, then pulses sr_load and reports the captured word.
module shiftreg_rw_ctrl #(
  parameter int WIDTH   = 32,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic             sr_clk,
  output logic             sr_din,
  input  logic             sr_dout,
  output logic             sr_load
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LOAD     = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] out_sr_q, out_sr_d;
  logic [WIDTH-1:0] cap_sr_q, cap_sr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sr_clk_q, sr_clk_d;
  logic             sr_din_q, sr_din_d;
  logic             sr_load_q, sr_load_d;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    out_sr_d = out_sr_q;
    cap_sr_d = cap_sr_q;
    dout_d   = dout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = SHIFT_LO;
          div_d    = '0;
          bit_d    = '0;
          out_sr_d = din;
          cap_sr_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT_LO: begin
        if (div_q == DIV_LAST) begin
          state_d = SHIFT_HI;
          div_d   = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      SHIFT_HI: begin
        // Capture during the first high cycle, when the chip output has settled.
        if (div_q == '0) begin
          cap_sr_d = {cap_sr_q[WIDTH-2:0], sr_dout};
        end
        if (div_q == DIV_LAST) begin
          div_d    = '0;
          out_sr_d = out_sr_q << 1;
          bit_d    = bit_q + CW'(1);
          state_d  = (bit_q == BIT_LAST) ? LOAD : SHIFT_LO;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      LOAD: begin
        if (div_q == DIV_LAST) begin
          state_d = DONE;
          div_d   = '0;
          dout_d  = cap_sr_q;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    busy_d    = (state_d == SHIFT_LO) || (state_d == SHIFT_HI) || (state_d == LOAD);
    done_d    = (state_d == DONE);
    sr_clk_d  = (state_d == SHIFT_HI);
    sr_load_d = (state_d == LOAD);
    sr_din_d  = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? out_sr_d[WIDTH-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      out_sr_q  <= '0;
      cap_sr_q  <= '0;
      dout_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sr_clk_q  <= 1'b0;
      sr_din_q  <= 1'b0;
      sr_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      out_sr_q  <= out_sr_d;
      cap_sr_q  <= cap_sr_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sr_clk_q  <= sr_clk_d;
      sr_din_q  <= sr_din_d;
      sr_load_q <= sr_load_d;
    end
  end

  assign dout    = dout_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sr_clk  = sr_clk_q;
  assign sr_din  = sr_din_q;
  assign sr_load = sr_load_q;

endmodule
